// File: rtl/cve2_fp_wb_scoreboard.sv
// cve2_fp_wb_scoreboard: FP destination pending bitmap with a round-robin FPU/LSU write-back arbiter
module cve2_fp_wb_scoreboard #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_rd_i,
  output logic                 issue_ready_o,
  input  logic                 fpu_valid_i,
  input  logic [4:0]           fpu_rd_i,
  input  logic [DataWidth-1:0] fpu_wdata_i,
  output logic                 fpu_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_rd_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_ready_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 we_a_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [4:0]           raddr_c_i,
  output logic                 busy_a_o,
  output logic                 busy_b_o,
  output logic                 busy_c_o
);
  localparam int AW = RV32E ? 4 : 5;
  localparam int NW = 1 << AW;
  logic [NW-1:0]        pending_q, pending_d, set_m, clr_m;
  logic                 last_lsu_q, fpu_gnt, lsu_gnt, gnt, we_q;
  logic [4:0]           waddr_q;
  logic [DataWidth-1:0] wdata_q;
  assign issue_ready_o = ~pending_q[issue_rd_i[AW-1:0]];
  assign busy_a_o      = pending_q[raddr_a_i[AW-1:0]];
  assign busy_b_o      = pending_q[raddr_b_i[AW-1:0]];
  assign busy_c_o      = pending_q[raddr_c_i[AW-1:0]];
  // FPU wins a contested cycle only when the LSU was granted last
  assign fpu_gnt     = fpu_valid_i & (~lsu_valid_i | last_lsu_q);
  assign lsu_gnt     = lsu_valid_i & ~fpu_gnt;
  assign gnt         = fpu_gnt | lsu_gnt;
  assign fpu_ready_o = fpu_gnt;
  assign lsu_ready_o = lsu_gnt;
  assign we_a_o      = we_q;
  assign waddr_a_o   = waddr_q;
  assign wdata_a_o   = wdata_q;
  // set is applied after clear so a same-bit collision leaves the bit pending
  always_comb begin
    set_m     = (issue_valid_i & issue_ready_o) ? NW'(1) << issue_rd_i[AW-1:0] : '0;
    clr_m     = we_q ? NW'(1) << waddr_q[AW-1:0] : '0;
    pending_d = (pending_q & ~clr_m) | set_m;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      last_lsu_q <= 1'b1;
    end else begin
      pending_q <= pending_d;
      we_q      <= gnt;
      if (gnt) begin
        waddr_q    <= fpu_gnt ? fpu_rd_i : lsu_rd_i;
        wdata_q    <= fpu_gnt ? fpu_wdata_i : lsu_wdata_i;
        last_lsu_q <= lsu_gnt;
      end
    end
  end
endmodule

// File: tb/tb_cve2_fp_wb_scoreboard.sv
// tb_cve2_fp_wb_scoreboard: directed scoreboard bench for the FP write-back scoreboard
module tb_cve2_fp_wb_scoreboard;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0, fpu_valid = 1'b0, lsu_valid = 1'b0;
  logic [4:0]  issue_rd = '0, fpu_rd = '0, lsu_rd = '0;
  logic [31:0] fpu_wdata = '0, lsu_wdata = '0;
  logic [4:0]  raddr_a = '0, raddr_b = '0, raddr_c = '0;
  logic        issue_ready, fpu_ready, lsu_ready, we, busy_a, busy_b, busy_c;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        e_issue_ready, e_fpu_ready, e_lsu_ready, e_we, e_busy_a, e_busy_b, e_busy_c;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;
  int          total = 0, bad = 0, we_cnt = 0;
  logic [36:0] exp_q[$];
  logic [36:0] item;
  bit          m_last_lsu;
  logic [4:0]  f_rd[2], l_rd[2];
  logic [31:0] f_d[2], l_d[2];
  int          fi, li;
  bit          gf;

  always #5 clk = ~clk;

  cve2_fp_wb_scoreboard #(.RV32E(1'b0), .DataWidth(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready),
    .fpu_valid_i(fpu_valid), .fpu_rd_i(fpu_rd), .fpu_wdata_i(fpu_wdata), .fpu_ready_o(fpu_ready),
    .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready),
    .waddr_a_o(waddr), .wdata_a_o(wdata), .we_a_o(we),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
    .busy_a_o(busy_a), .busy_b_o(busy_b), .busy_c_o(busy_c)
  );

  cve2_fp_wb_scoreboard #(.RV32E(1'b1), .DataWidth(32)) dut_e (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(e_issue_ready),
    .fpu_valid_i(fpu_valid), .fpu_rd_i(fpu_rd), .fpu_wdata_i(fpu_wdata), .fpu_ready_o(e_fpu_ready),
    .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(e_lsu_ready),
    .waddr_a_o(e_waddr), .wdata_a_o(e_wdata), .we_a_o(e_we),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
    .busy_a_o(e_busy_a), .busy_b_o(e_busy_b), .busy_c_o(e_busy_c)
  );

  task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) chk("unexpected_write", {waddr, wdata}, 37'h0);
      else begin
        item = exp_q.pop_front();
        chk("write_port", {waddr, wdata}, item);
      end
    end
  end

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_we", we, 1'b0);
    chk("rst_waddr", waddr, 5'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_issue_ready", issue_ready, 1'b1);
    chk("rst_busy", {busy_a, busy_b, busy_c}, 3'b000);
    issue_valid = 1'b1; issue_rd = 5'd5; raddr_a = 5'd5;
    #1 chk("busy_before_issue", busy_a, 1'b0);
    step();
    issue_valid = 1'b0;
    chk("busy_after_issue", busy_a, 1'b1);
    lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_wdata = 32'h3F800000;
    #1 chk("lsu_sole_ready", {fpu_ready, lsu_ready}, 2'b01);
    exp_q.push_back({5'd5, 32'h3F800000});
    step();
    lsu_valid = 1'b0;
    chk("we_after_grant", we, 1'b1);
    chk("busy_during_write", busy_a, 1'b1);
    step();
    chk("we_single_pulse", we, 1'b0);
    chk("busy_cleared", busy_a, 1'b0);
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    #1 chk("waw_stall_7", issue_ready, 1'b0);
    issue_rd = 5'd8;
    #1 chk("no_stall_8", issue_ready, 1'b1);
    issue_rd = 5'd7;
    fpu_valid = 1'b1; fpu_rd = 5'd7; fpu_wdata = 32'hC0490FDB;
    #1 chk("fpu_sole_ready", {fpu_ready, lsu_ready}, 2'b10);
    exp_q.push_back({5'd7, 32'hC0490FDB});
    step();
    fpu_valid = 1'b0;
    chk("stall_during_write", issue_ready, 1'b0);
    step();
    chk("stall_released", issue_ready, 1'b1);
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_wdata = 32'h12345678; raddr_b = 5'd9;
    exp_q.push_back({5'd9, 32'h12345678});
    step();
    lsu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1 chk("unpending_write_issue_ok", issue_ready, 1'b1);
    step();
    issue_valid = 1'b0;
    chk("set_wins_over_clear", busy_b, 1'b1);
    fpu_valid = 1'b1; fpu_rd = 5'd9; fpu_wdata = 32'hAAAA5555;
    exp_q.push_back({5'd9, 32'hAAAA5555});
    step();
    fpu_valid = 1'b0;
    step();
    chk("busy9_cleared", busy_b, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_last_lsu = 1'b1;
    f_rd = '{5'd10, 5'd11}; f_d = '{32'h11110000, 32'h11112222};
    l_rd = '{5'd20, 5'd21}; l_d = '{32'h22220000, 32'h22223333};
    fi = 0; li = 0; raddr_b = 5'd20;
    for (int i = 0; i < 4; i++) begin
      fpu_valid = fi < 2; lsu_valid = li < 2;
      fpu_rd = f_rd[fi % 2]; fpu_wdata = f_d[fi % 2];
      lsu_rd = l_rd[li % 2]; lsu_wdata = l_d[li % 2];
      gf = fpu_valid && (!lsu_valid || m_last_lsu);
      #1 chk("rr_grant", {fpu_ready, lsu_ready}, {gf, !gf});
      exp_q.push_back(gf ? {fpu_rd, fpu_wdata} : {lsu_rd, lsu_wdata});
      if (i > 0) chk("no_bubble", we, 1'b1);
      m_last_lsu = !gf;
      if (gf) fi++; else li++;
      step();
    end
    fpu_valid = 1'b0; lsu_valid = 1'b0;
    chk("last_pulse", we, 1'b1);
    chk("unpending_write_busy", busy_b, 1'b0);
    step();
    chk("burst_end", we, 1'b0);
    issue_valid = 1'b1; issue_rd = 5'd3; raddr_c = 5'd3;
    step();
    issue_valid = 1'b0;
    chk("busy3_set", busy_c, 1'b1);
    fpu_valid = 1'b1; fpu_rd = 5'd3; fpu_wdata = 32'hDEADBEEF; rst = 1'b1;
    #1 chk("ready_in_reset", fpu_ready, 1'b1);
    step();
    rst = 1'b0; fpu_valid = 1'b0;
    chk("grant_discarded", we, 1'b0);
    chk("busy3_reset", busy_c, 1'b0);
    chk("issue_ready_reset", issue_ready, 1'b1);
    issue_valid = 1'b1; issue_rd = 5'd17; raddr_a = 5'd1; raddr_b = 5'd17;
    step();
    issue_valid = 1'b0;
    chk("e_busy_1", e_busy_a, 1'b1);
    chk("e_busy_17", e_busy_b, 1'b1);
    chk("full_busy_1", busy_a, 1'b0);
    chk("full_busy_17", busy_b, 1'b1);
    step();
    chk("we_pulse_count", we_cnt, 8);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
